// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - register addresses, edge-type codes and edge-match helper for pio_in_edge_irq
package pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd2;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    function automatic logic edge_match(input logic prev, input logic cur, input int edge_type);
        logic hit;
        case (edge_type)
            EDGE_RISING:  hit = ~prev & cur;
            EDGE_FALLING: hit = prev & ~cur;
            EDGE_ANY:     hit = prev ^ cur;
            default:      hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pio_in_debounce.sv
// rtl/pio_in_debounce.sv - one input bit: metastability chain plus optional debounce (PIO_IN_DEBOUNCE_EN)
module pio_in_debounce #(
    parameter int SYNC_STAGES = 2
`ifdef PIO_IN_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 1000
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level
);

    logic [SYNC_STAGES-1:0] sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0] cnt;

    // Count consecutive samples that disagree with the held level; any agreeing sample restarts the run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync[SYNC_STAGES-1] == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync[SYNC_STAGES-1];
        end else begin
            cnt <= cnt + 16'd1;
        end
    end
`else
    assign level = sync[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/pio_in_edge_irq.sv
// rtl/pio_in_edge_irq.sv - input PIO slave with per-bit edge capture and masked level irq
// Optional debounce of each input bit is built when PIO_IN_DEBOUNCE_EN is defined.
module pio_in_edge_irq
    import pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
`ifdef PIO_IN_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 1000
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int                ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] wdata;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;
    logic             wr;
    logic [31:0]      rd_mux;

    assign wr    = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];
    assign armed = (arm_cnt == ARM_DONE);

    if (WIDTH < 32) begin : g_wdata_hi
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^writedata[31:WIDTH];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_in_debounce #(
            .SYNC_STAGES     (SYNC_STAGES)
`ifdef PIO_IN_DEBOUNCE_EN
            ,
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
        ) u_in (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[i]),
            .level   (level[i])
        );

        assign edge_set[i] = armed & edge_match(prev[i], level[i], EDGE_TYPE);
    end

    assign edge_clr = (wr && address == PIO_ADDR_EDGECAP) ? wdata : '0;

    // prev keeps following level while disarmed so pins already high at reset never look like edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev     <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
            arm_cnt  <= '0;
        end else begin
            prev <= level;
            if (!armed) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
            if (wr && address == PIO_ADDR_IRQMASK) begin
                irq_mask <= wdata;
            end
            edge_cap <= (edge_cap & ~edge_clr) | edge_set;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            PIO_ADDR_DATA:    rd_mux[WIDTH-1:0] = level;
            PIO_ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
            PIO_ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap;
            default:          rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule
